// File: rtl/program_sequencer.sv
// Instruction sequencer for the simple processor: holds a small program and
// presents instruction/immediate words on Din with the run/Done handshake.
module program_sequencer #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [8:0]    prog_wdata,
  input  logic          done_i,
  output logic [8:0]    din_o,
  output logic          run_o,
  output logic          busy,
  output logic          halted,
  output logic          error,
  output logic [AW-1:0] pc,
  output logic [7:0]    retired
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_IMM, S_STOP, S_ERR
  } state_t;

  logic [8:0]     r_mem [DEPTH];
  state_t         r_state, w_state_nx;
  logic [AW:0]    r_pc, w_pc_nx;
  logic [AW:0]    r_len, w_len_nx;
  logic [WDW-1:0] r_wd, w_wd_nx;
  logic [7:0]     r_retired, w_retired_nx;
  logic           r_run, r_busy, r_halted, r_error;
  logic [AW:0]    w_pc_p1;
  logic [8:0]     w_word, w_imm;
  logic [2:0]     w_op;

  // Program memory: no reset, writes locked out while executing
  always_ff @(posedge clk) begin
    if (prog_we && !r_busy) r_mem[prog_addr] <= prog_wdata;
  end

  assign w_pc_p1 = r_pc + (AW+1)'(1);
  assign w_word  = r_mem[r_pc[AW-1:0]];
  assign w_imm   = r_mem[w_pc_p1[AW-1:0]];
  assign w_op    = w_word[8:6];

  // Din is an asynchronous memory read qualified by the registered state
  always_comb begin
    din_o = 9'd0;
    case (r_state)
      S_LOAD, S_ISSUE, S_WAIT: din_o = w_word;
      S_IMM:                   din_o = w_imm;
      default:                 din_o = 9'd0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_len     <= '0;
      r_wd      <= '0;
      r_retired <= '0;
      r_run     <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_len     <= w_len_nx;
      r_wd      <= w_wd_nx;
      r_retired <= w_retired_nx;
      r_run     <= (w_state_nx == S_ISSUE) || (w_state_nx == S_IMM);
      r_busy    <= (w_state_nx == S_LOAD) || (w_state_nx == S_ISSUE) ||
                   (w_state_nx == S_WAIT) || (w_state_nx == S_IMM);
      r_halted  <= (w_state_nx == S_STOP);
      r_error   <= (w_state_nx == S_ERR);
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_len_nx     = r_len;
    w_wd_nx      = r_wd;
    w_retired_nx = r_retired;
    case (r_state)
      S_IDLE, S_STOP, S_ERR: begin
        if (start) begin
          w_len_nx     = prog_len;
          w_pc_nx      = '0;
          w_retired_nx = '0;
          w_state_nx   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_pc >= r_len) begin
          w_state_nx = S_STOP;
        end else if (w_op == 3'b111) begin
          w_state_nx = S_STOP;
        end else if (w_op[2]) begin
          w_pc_nx = w_pc_p1;
        end else if ((w_op == 3'b001) && (w_pc_p1 >= r_len)) begin
          w_state_nx = S_ERR;
        end else begin
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_wd_nx    = '0;
        w_state_nx = (w_op == 3'b001) ? S_IMM : S_WAIT;
      end
      S_WAIT, S_IMM: begin
        // Done in the final watchdog cycle still retires the instruction
        if (done_i) begin
          if (r_retired != 8'hFF) w_retired_nx = r_retired + 8'd1;
          w_pc_nx    = (r_state == S_IMM) ? r_pc + (AW+1)'(2) : w_pc_p1;
          w_state_nx = S_LOAD;
        end else begin
          w_wd_nx = r_wd + WDW'(1);
          if (w_wd_nx == WDW'(TIMEOUT)) w_state_nx = S_ERR;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign run_o   = r_run;
  assign busy    = r_busy;
  assign halted  = r_halted;
  assign error   = r_error;
  assign pc      = r_pc[AW-1:0];
  assign retired = r_retired;

endmodule
